score_hex_display: RTL and testbench



---
 rtl/score_hex_display.sv | 195 +++++++++++++++++++
 tb/tb_score_hex_display.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_hex_display.sv
// rtl/score_hex_display.sv - binary score/level to eight active-low seven-segment displays
//
// Purpose: converts an SCORE_W-bit binary score into DIGITS BCD digits with a
// sequential double-dabble engine (one bit per clock) and the 4-bit level into
// two decimal digits, then registers all eight segment patterns at once so the
// displays never show a partially converted value. A conversion starts only
// when {iScore, iLevel} differs from the last converted value.
//
// Optional feature macro: SCORE_HEX_LZ_BLANK_EN (leading-zero blanking of the
// score digits and of the level tens digit). Undefined: all digits shown.
//
// Ports:
//   iVGA_CLK      pixel clock, all logic on its rising edge
//   iRST_n        synchronous active-low reset
//   iScore        binary score, SCORE_W bits
//   iLevel        binary level, 0..15
//   oHEX0..oHEX5  score digit segments {g,f,e,d,c,b,a}, HEX0 = least significant
//   oHEX6, oHEX7  level units / tens segments
//   oBusy         high while a conversion is in progress
//   oValid        one-cycle pulse when new display values are committed

module score_hex_display #(
   parameter int SCORE_W = 18,
   parameter int DIGITS  = 6
) (
   input  logic               iVGA_CLK,
   input  logic               iRST_n,
   input  logic [SCORE_W-1:0] iScore,
   input  logic [3:0]         iLevel,
   output logic [6:0]         oHEX0,
   output logic [6:0]         oHEX1,
   output logic [6:0]         oHEX2,
   output logic [6:0]         oHEX3,
   output logic [6:0]         oHEX4,
   output logic [6:0]         oHEX5,
   output logic [6:0]         oHEX6,
   output logic [6:0]         oHEX7,
   output logic               oBusy,
   output logic               oValid
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_SHIFT  = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   logic [1:0]         r_state;
   logic [SCORE_W-1:0] r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_level;
   logic [SCORE_W-1:0] r_last_score;
   logic [3:0]         r_last_level;
   logic               r_last_vld;
   logic [6:0]         r_score_hex [DIGITS];
   logic [6:0]         r_lvl_units_hex;
   logic [6:0]         r_lvl_tens_hex;
   logic               r_busy;
   logic               r_valid;

   logic [BCD_W-1:0]   w_bcd_adj;
   logic [6:0]         w_score_seg [DIGITS];
   logic               w_lvl_tens;
   logic [3:0]         w_lvl_units;
   logic [6:0]         w_lvl_tens_seg;
   logic               w_changed;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction: any nibble >= 5 would become >= 10 after the
   // shift, so pre-add 3 to carry it into the next decimal digit.
   always_comb begin
      w_bcd_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         else
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
   end

   // Score digit segments; with blanking, walk from the MSD down and show a
   // digit once a nonzero digit has been seen (HEX0 is always shown).
   always_comb begin : score_seg
      logic v_seen;
      v_seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (r_bcd[4*i +: 4] != 4'd0 || i == 0)
            v_seen = 1'b1;
`ifdef SCORE_HEX_LZ_BLANK_EN
         w_score_seg[i] = v_seen ? seg7(r_bcd[4*i +: 4]) : SEG_BLANK;
`else
         w_score_seg[i] = seg7(r_bcd[4*i +: 4]);
`endif
      end
   end

   assign w_lvl_tens  = (r_level >= 4'd10);
   assign w_lvl_units = w_lvl_tens ? (r_level - 4'd10) : r_level;

`ifdef SCORE_HEX_LZ_BLANK_EN
   assign w_lvl_tens_seg = w_lvl_tens ? seg7(4'd1) : SEG_BLANK;
`else
   assign w_lvl_tens_seg = seg7({3'b000, w_lvl_tens});
`endif

   assign w_changed = !r_last_vld || (iScore != r_last_score) || (iLevel != r_last_level);

   always_ff @(posedge iVGA_CLK) begin
      if (!iRST_n) begin
         r_state         <= S_IDLE;
         r_bin           <= '0;
         r_bcd           <= '0;
         r_cnt           <= '0;
         r_level         <= '0;
         r_last_score    <= '0;
         r_last_level    <= '0;
         r_last_vld      <= 1'b0;
         for (int i = 0; i < DIGITS; i++)
            r_score_hex[i] <= SEG_BLANK;
         r_lvl_units_hex <= SEG_BLANK;
         r_lvl_tens_hex  <= SEG_BLANK;
         r_busy          <= 1'b0;
         r_valid         <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_changed)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_bin        <= iScore;
               r_level      <= iLevel;
               r_last_score <= iScore;
               r_last_level <= iLevel;
               r_bcd        <= '0;
               r_cnt        <= CNT_W'(SCORE_W);
               r_busy       <= 1'b1;
               r_state      <= S_SHIFT;
            end
            S_SHIFT: begin
               // {bcd, bin} <<= 1 using the corrected BCD nibbles
               r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
               r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1))
                  r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               for (int i = 0; i < DIGITS; i++)
                  r_score_hex[i] <= w_score_seg[i];
               r_lvl_units_hex <= seg7(w_lvl_units);
               r_lvl_tens_hex  <= w_lvl_tens_seg;
               r_last_vld      <= 1'b1;
               r_valid         <= 1'b1;
               r_busy          <= 1'b0;
               r_state         <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign oHEX0  = r_score_hex[0];
   assign oHEX1  = r_score_hex[1];
   assign oHEX2  = r_score_hex[2];
   assign oHEX3  = r_score_hex[3];
   assign oHEX4  = r_score_hex[4];
   assign oHEX5  = r_score_hex[5];
   assign oHEX6  = r_lvl_units_hex;
   assign oHEX7  = r_lvl_tens_hex;
   assign oBusy  = r_busy;
   assign oValid = r_valid;

endmodule

// File: tb/tb_score_hex_display.sv
// tb/tb_score_hex_display.sv - self-checking bench for score_hex_display

`timescale 1ns/1ps

module tb_score_hex_display;

   localparam int SW = 18;
`ifdef SCORE_HEX_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif
   localparam logic [6:0] BL = 7'h7F;
   localparam logic [6:0] ZL = LZ ? 7'h7F : 7'b1000000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [17:0] score;
   logic [3:0]  level;
   logic [6:0]  dut_hex [8];
   logic        busy;
   logic        vld;

   always #5 clk = ~clk;

   score_hex_display #(.SCORE_W(SW), .DIGITS(6)) dut (
      .iVGA_CLK (clk),
      .iRST_n   (rstn),
      .iScore   (score),
      .iLevel   (level),
      .oHEX0    (dut_hex[0]),
      .oHEX1    (dut_hex[1]),
      .oHEX2    (dut_hex[2]),
      .oHEX3    (dut_hex[3]),
      .oHEX4    (dut_hex[4]),
      .oHEX5    (dut_hex[5]),
      .oHEX6    (dut_hex[6]),
      .oHEX7    (dut_hex[7]),
      .oBusy    (busy),
      .oValid   (vld)
   );

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   function automatic int pow10(input int n);
      int p = 1;
      for (int j = 0; j < n; j++) p = p * 10;
      return p;
   endfunction

   // Expected segments of display idx for a committed (score, level) pair.
   function automatic logic [6:0] exp_seg(input int idx, input int s, input int l);
      int p;
      int tens;
      if (idx < 6) begin
         p = pow10(idx);
         if (LZ && idx > 0 && s < p) return BL;
         return seg_tab[(s / p) % 10];
      end
      tens = (l >= 10) ? 1 : 0;
      if (idx == 6) return seg_tab[l - 10 * tens];
      if (LZ && tens == 0) return BL;
      return seg_tab[tens];
   endfunction

   // Behavioural model: a conversion is a timeline of edges counted from the
   // edge where a change is noticed while idle; inputs are sampled one edge
   // later and the result appears SW+2 edges after detection.
   int          m_cnt = 0;
   bit          m_flag = 1'b0;
   bit          m_started = 1'b0;
   logic [17:0] m_last_s = '0;
   logic [3:0]  m_last_l = '0;
   logic [17:0] m_cap_s = '0;
   logic [3:0]  m_cap_l = '0;
   logic [6:0]  m_hex [8];
   bit          m_busy = 1'b0;
   bit          m_vld = 1'b0;

   always @(posedge clk) begin
      m_started <= 1'b1;
      if (!rstn) begin
         m_cnt  <= 0;
         m_flag <= 1'b0;
         m_busy <= 1'b0;
         m_vld  <= 1'b0;
         for (int k = 0; k < 8; k++) m_hex[k] <= BL;
      end else begin
         m_vld <= 1'b0;
         if (m_cnt == 0) begin
            if (!m_flag || score != m_last_s || level != m_last_l) m_cnt <= 1;
         end else if (m_cnt == 1) begin
            m_cap_s  <= score;
            m_cap_l  <= level;
            m_last_s <= score;
            m_last_l <= level;
            m_busy   <= 1'b1;
            m_cnt    <= 2;
         end else if (m_cnt == SW + 2) begin
            for (int k = 0; k < 8; k++) m_hex[k] <= exp_seg(k, int'(m_cap_s), int'(m_cap_l));
            m_busy <= 1'b0;
            m_vld  <= 1'b1;
            m_flag <= 1'b1;
            m_cnt  <= 0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   int         busy_len = 0;
   int         pin_req = 0;
   int         pin_ack = 0;
   int         pin_age = 0;
   logic [6:0] pin_hex [8];

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_started) begin
         for (int k = 0; k < 8; k++)
            check($sformatf("hex%0d", k), int'(dut_hex[k]), int'(m_hex[k]));
         check("busy", int'(busy), int'(m_busy));
         check("valid", int'(vld), int'(m_vld));
         if (vld) begin
            check("busy_len", busy_len, SW + 1);
            busy_len = 0;
         end
         if (!rstn) busy_len = 0;
         else if (busy) busy_len++;
         if (pin_req != pin_ack) begin
            pin_age++;
            if (vld) begin
               for (int k = 0; k < 8; k++)
                  check($sformatf("pin%0d_hex%0d", pin_ack, k), int'(dut_hex[k]), int'(pin_hex[k]));
               pin_ack++;
               pin_age = 0;
            end else if (pin_age > 80) begin
               n_cmp++;
               n_bad++;
               $display("FAIL pin%0d_timeout: got no valid pulse, expected one within 80 cycles", pin_ack);
               pin_ack++;
               pin_age = 0;
            end
         end
      end
   end

   task automatic set_pin(input logic [6:0] h5, input logic [6:0] h4, input logic [6:0] h3,
                          input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0,
                          input logic [6:0] h7, input logic [6:0] h6);
      pin_hex[0] = h0; pin_hex[1] = h1; pin_hex[2] = h2; pin_hex[3] = h3;
      pin_hex[4] = h4; pin_hex[5] = h5; pin_hex[6] = h6; pin_hex[7] = h7;
      pin_req++;
   endtask

   task automatic wait_pin();
      wait (pin_ack == pin_req);
   endtask

   task automatic drive(input int s, input int l);
      @(negedge clk);
      #1;
      score = 18'(s);
      level = 4'(l);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      rstn  = 1'b0;
      score = '0;
      level = '0;
      repeat (3) @(negedge clk);

      // reset release with 0/0
      set_pin(ZL, ZL, ZL, ZL, ZL, 7'b1000000, ZL, 7'b1000000);
      #1 rstn = 1'b1;
      wait_pin();

      // 123456, level 7
      set_pin(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
              ZL, 7'b1111000);
      drive(123456, 7);
      wait_pin();

      // maximum score, level 15
      set_pin(7'b0100100, 7'b0000010, 7'b0100100, 7'b1111001, 7'b0011001, 7'b0110000,
              7'b1111001, 7'b0010010);
      drive(262143, 15);
      wait_pin();

      // input changes mid-conversion: 100 committed first, then 200
      set_pin(ZL, ZL, ZL, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1111001, 7'b0010010);
      drive(100, 15);
      repeat (5) @(negedge clk);
      #1 score = 18'd200;
      wait_pin();
      set_pin(ZL, ZL, ZL, 7'b0100100, 7'b1000000, 7'b1000000, 7'b1111001, 7'b0010010);
      wait_pin();

      // reset mid-conversion, then full reconversion of 555 / level 9
      set_pin(ZL, ZL, ZL, 7'b0010010, 7'b0010010, 7'b0010010, ZL, 7'b0010000);
      drive(555, 9);
      repeat (11) @(negedge clk);
      reset_pulse();
      wait_pin();

      // 42, level 3
      set_pin(ZL, ZL, ZL, ZL, 7'b0011001, 7'b0100100, ZL, 7'b0110000);
      drive(42, 3);
      wait_pin();

      // randomized traffic, occasional resets
      for (int it = 0; it < 40; it++) begin
         drive(int'($urandom_range(0, 262143)), int'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 30)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) reset_pulse();
      end

      repeat (30) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
